bcd_xs3_arbiter: RTL and testbench



---
 rtl/bcd_xs3_arbiter_pkg.sv | 12 +
 rtl/bcd_xs3_core.sv | 16 +
 rtl/bcd_xs3_arbiter.sv | 128 ++++++++++++
 tb/tb_bcd_xs3_arbiter.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/bcd_xs3_arbiter_pkg.sv
// Shared constants and FSM state encoding for the BCD to Excess-3 arbiter slice.
package bcd_xs3_arbiter_pkg;

  localparam logic [3:0] XS3_OFFSET = 4'd3;
  localparam logic [3:0] BCD_MAX    = 4'd9;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_HOLD = 1'b1
  } state_t;

endpackage

// File: rtl/bcd_xs3_core.sv
// Combinational BCD to Excess-3 converter; digits above 9 are flagged, not converted.
module bcd_xs3_core
  import bcd_xs3_arbiter_pkg::*;
(
  input  logic [3:0] in_digit,
  output logic [3:0] out_code,
  output logic       out_err
);

  logic w_err;

  assign w_err    = (in_digit > BCD_MAX);
  assign out_err  = w_err;
  assign out_code = w_err ? '0 : (in_digit + XS3_OFFSET);

endmodule

// File: rtl/bcd_xs3_arbiter.sv
// Round-robin arbiter sharing one BCD to Excess-3 core, with a one-entry valid/ready output register.
// Optional error counter built only when BCD_XS3_ERR_COUNT_EN is defined.
module bcd_xs3_arbiter
  import bcd_xs3_arbiter_pkg::*;
#(
  parameter int unsigned NREQ = 4,
  parameter int unsigned IDW  = 2
) (
  input  logic              in_clk,
  input  logic              in_rst_n,
  input  logic [NREQ-1:0]   in_req,
  input  logic [4*NREQ-1:0] in_digit,
  output logic [NREQ-1:0]   out_gnt,
  output logic              out_valid,
  input  logic              in_ready,
  output logic [IDW-1:0]    out_id,
  output logic [3:0]        out_code,
  output logic              out_err,
  output logic [7:0]        out_err_cnt
);

  localparam logic [IDW-1:0] LAST_IDX = IDW'(NREQ - 1);

  state_t          r_state;
  state_t          w_state_nxt;
  logic [IDW-1:0]  r_ptr;
  logic [IDW-1:0]  r_id;
  logic [3:0]      r_code;
  logic            r_err;

  logic            w_accept;
  logic            w_fire;
  logic            w_found_hi;
  logic            w_found_lo;
  logic [IDW-1:0]  w_win_hi;
  logic [IDW-1:0]  w_win_lo;
  logic [IDW-1:0]  w_win;
  logic [3:0]      w_digit;
  logic [3:0]      w_code;
  logic            w_err;

  assign w_accept = (r_state == ST_IDLE) || in_ready;
  assign w_fire   = in_rst_n && w_accept && (|in_req);

  // Two scans: first request at/above the pointer wins, else the lowest request overall (wrap).
  always_comb begin
    w_found_hi = 1'b0;
    w_found_lo = 1'b0;
    w_win_hi   = '0;
    w_win_lo   = '0;
    for (int unsigned j = 0; j < NREQ; j++) begin
      if (in_req[j] && !w_found_hi && (j >= 32'(r_ptr))) begin
        w_found_hi = 1'b1;
        w_win_hi   = IDW'(j);
      end
      if (in_req[j] && !w_found_lo) begin
        w_found_lo = 1'b1;
        w_win_lo   = IDW'(j);
      end
    end
    w_win = w_found_hi ? w_win_hi : w_win_lo;
  end

  always_comb begin
    w_digit = '0;
    for (int unsigned j = 0; j < NREQ; j++) begin
      if (IDW'(j) == w_win) w_digit = in_digit[4*j +: 4];
    end
  end

  always_comb begin
    out_gnt = '0;
    if (w_fire) out_gnt = NREQ'(1) << w_win;
  end

  bcd_xs3_core u_core (
    .in_digit (w_digit),
    .out_code (w_code),
    .out_err  (w_err)
  );

  always_ff @(posedge in_clk) begin
    if (!in_rst_n) r_state <= ST_IDLE;
    else           r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (w_fire)                               w_state_nxt = ST_HOLD;
    else if (r_state == ST_HOLD && in_ready)  w_state_nxt = ST_IDLE;
  end

  always_comb begin
    out_valid = (r_state == ST_HOLD);
  end

  always_ff @(posedge in_clk) begin
    if (!in_rst_n) begin
      r_ptr  <= '0;
      r_id   <= '0;
      r_code <= '0;
      r_err  <= 1'b0;
    end else if (w_fire) begin
      r_ptr  <= (w_win == LAST_IDX) ? '0 : (w_win + 1'b1);
      r_id   <= w_win;
      r_code <= w_code;
      r_err  <= w_err;
    end
  end

  assign out_id   = r_id;
  assign out_code = r_code;
  assign out_err  = r_err;

`ifdef BCD_XS3_ERR_COUNT_EN
  logic [7:0] r_err_cnt;

  always_ff @(posedge in_clk) begin
    if (!in_rst_n)                                 r_err_cnt <= '0;
    else if (w_fire && w_err && (r_err_cnt != '1)) r_err_cnt <= r_err_cnt + 8'd1;
  end

  assign out_err_cnt = r_err_cnt;
`else
  assign out_err_cnt = '0;
`endif

endmodule

// File: tb/tb_bcd_xs3_arbiter.sv
// Directed self-checking bench for bcd_xs3_arbiter (NREQ=4, IDW=2).
module tb_bcd_xs3_arbiter;

  logic        in_clk;
  logic        in_rst_n;
  logic [3:0]  in_req;
  logic [15:0] in_digit;
  logic [3:0]  out_gnt;
  logic        out_valid;
  logic        in_ready;
  logic [1:0]  out_id;
  logic [3:0]  out_code;
  logic        out_err;
  logic [7:0]  out_err_cnt;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;
  int unsigned n_grants = 0;
  logic [7:0]  exp_cnt_one;
  logic [7:0]  exp_cnt_sat;

  bcd_xs3_arbiter #(.NREQ(4), .IDW(2)) dut (
    .in_clk      (in_clk),
    .in_rst_n    (in_rst_n),
    .in_req      (in_req),
    .in_digit    (in_digit),
    .out_gnt     (out_gnt),
    .out_valid   (out_valid),
    .in_ready    (in_ready),
    .out_id      (out_id),
    .out_code    (out_code),
    .out_err     (out_err),
    .out_err_cnt (out_err_cnt)
  );

  initial in_clk = 1'b0;
  always #5 in_clk = ~in_clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge in_clk);
    #1;
  endtask

  initial begin
`ifdef BCD_XS3_ERR_COUNT_EN
    exp_cnt_one = 8'd1;
    exp_cnt_sat = 8'hFF;
`else
    exp_cnt_one = 8'd0;
    exp_cnt_sat = 8'd0;
`endif
    in_rst_n = 1'b0;
    in_req   = 4'b1111;
    in_digit = 16'h0000;
    in_ready = 1'b1;
    step();
    step();
    chk("rst_gnt", 32'(out_gnt), 32'h0);
    chk("rst_valid", 32'(out_valid), 32'h0);
    chk("rst_id", 32'(out_id), 32'h0);
    chk("rst_code", 32'(out_code), 32'h0);
    chk("rst_err", 32'(out_err), 32'h0);
    chk("rst_cnt", 32'(out_err_cnt), 32'h0);

    // single request, digit 6 -> code 9
    in_req   = 4'b0001;
    in_digit = 16'h0006;
    in_rst_n = 1'b1;
    #1 chk("single_gnt", 32'(out_gnt), 32'h1);
    step();
    in_req = 4'b0000;
    #1;
    chk("single_valid", 32'(out_valid), 32'h1);
    chk("single_id", 32'(out_id), 32'h0);
    chk("single_code", 32'(out_code), 32'h9);
    chk("single_err", 32'(out_err), 32'h0);
    chk("single_gnt_off", 32'(out_gnt), 32'h0);
    step();
    chk("single_drain", 32'(out_valid), 32'h0);

    // round robin from pointer 0, digits 1,2,3,4
    in_rst_n = 1'b0;
    step();
    in_rst_n = 1'b1;
    in_req   = 4'b1111;
    in_digit = 16'h4321;
    for (int k = 0; k < 5; k++) begin
      #1 chk("rr_gnt", 32'(out_gnt), 32'(4'b0001 << (k % 4)));
      step();
      chk("rr_valid", 32'(out_valid), 32'h1);
      chk("rr_id", 32'(out_id), 32'(k % 4));
      chk("rr_code", 32'(out_code), 32'((k % 4) + 4));
    end

    // backpressure: holding id0/code4, requester 1 waits
    in_ready = 1'b0;
    in_req   = 4'b0010;
    for (int k = 0; k < 5; k++) begin
      #1;
      chk("bp_gnt", 32'(out_gnt), 32'h0);
      chk("bp_valid", 32'(out_valid), 32'h1);
      chk("bp_id", 32'(out_id), 32'h0);
      chk("bp_code", 32'(out_code), 32'h4);
      step();
    end
    in_ready = 1'b1;
    #1 chk("bp_release_gnt", 32'(out_gnt), 32'h2);
    step();
    chk("bp_id1", 32'(out_id), 32'h1);
    chk("bp_code1", 32'(out_code), 32'h5);
    in_req = 4'b0000;
    step();
    chk("bp_drain", 32'(out_valid), 32'h0);

    // invalid digit 12 on requester 2, then saturate the counter
    in_digit = 16'h4C21;
    in_req   = 4'b0100;
    #1 chk("inv_gnt", 32'(out_gnt), 32'h4);
    step();
    #1;
    chk("inv_err", 32'(out_err), 32'h1);
    chk("inv_code", 32'(out_code), 32'h0);
    chk("inv_id", 32'(out_id), 32'h2);
    chk("inv_cnt1", 32'(out_err_cnt), 32'(exp_cnt_one));
    for (int k = 0; k < 299; k++) begin
      if (out_gnt == 4'b0100) n_grants++;
      step();
    end
    chk("inv_every_cycle", n_grants, 32'd299);
    chk("inv_cnt_sat", 32'(out_err_cnt), 32'(exp_cnt_sat));
    in_req = 4'b0000;
    step();

    // reset mid-transfer (pointer 3 before, 0 after)
    in_req = 4'b0001;
    #1 chk("mid_gnt", 32'(out_gnt), 32'h1);
    step();
    in_ready = 1'b0;
    in_req   = 4'b0000;
    #1 chk("mid_valid", 32'(out_valid), 32'h1);
    in_rst_n = 1'b0;
    step();
    in_rst_n = 1'b1;
    in_ready = 1'b1;
    #1;
    chk("mid_valid_clr", 32'(out_valid), 32'h0);
    chk("mid_code_clr", 32'(out_code), 32'h0);
    chk("mid_cnt_clr", 32'(out_err_cnt), 32'h0);
    in_req = 4'b1000;
    #1 chk("mid_gnt3", 32'(out_gnt), 32'h8);
    step();
    chk("mid_id3", 32'(out_id), 32'h3);
    chk("mid_code3", 32'(out_code), 32'h7);
    in_req = 4'b1001;
    #1 chk("mid_wrap_gnt", 32'(out_gnt), 32'h1);
    step();
    chk("mid_wrap_id", 32'(out_id), 32'h0);

    // wrap boundary: move pointer to 3, then 1001 -> 3 then 0
    in_req = 4'b0100;
    step();
    in_req = 4'b1001;
    #1 chk("wrap_gnt3", 32'(out_gnt), 32'h8);
    step();
    chk("wrap_id3", 32'(out_id), 32'h3);
    #1 chk("wrap_gnt0", 32'(out_gnt), 32'h1);
    step();
    chk("wrap_id0", 32'(out_id), 32'h0);
    chk("wrap_code0", 32'(out_code), 32'h4);
    in_req = 4'b0000;
    step();
    chk("end_idle", 32'(out_valid), 32'h0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
